// File: rtl/fphub_mult_arbiter.sv
// fphub_mult_arbiter
//   Lets N requesters share one FPHUB_mult instance. A requester is granted in
//   IDLE and its operands are registered toward the multiplier. The block then
//   pulses mul_start_o and waits for mul_finish_i. The product goes back on one
//   valid/ready response port, tagged with the id of the requester that owns it.
//   Operation sequence: IDLE (grant) -> ISSUE (start pulse) -> WAIT (finish)
//   -> RESP (hold product until the consumer takes it) -> IDLE.
//
// Configuration macro:
//   FPHUB_ARB_FIXED_PRIO_EN  defined   : fixed priority, lowest index wins,
//                                        and there is no round-robin pointer
//                            undefined : round-robin starting at the pointer
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active high
//   req_valid_i    [N]    requester i has an operand pair
//   req_ready_o    [N]    one-hot accept, asserted only in IDLE
//   req_x_i        [N*W]  operand X of requester i at [i*W +: W]
//   req_y_i        [N*W]  operand Y of requester i at [i*W +: W]
//   rsp_valid_o           product valid
//   rsp_ready_i           consumer accepts product
//   rsp_id_o       [ID_W] requester that owns rsp_z_o
//   rsp_z_o        [W]    HUB product
//   mul_start_o           one-cycle start pulse to the multiplier
//   mul_x_o/mul_y_o [W]   registered operands to the multiplier
//   mul_z_i        [W]    multiplier result, valid while mul_finish_i=1
//   mul_finish_i          multiplier done pulse
//   busy_o                high in any state other than IDLE

module fphub_mult_arbiter #(
  parameter int M    = 23,
  parameter int E    = 8,
  parameter int N    = 4,
  parameter int W    = E + M + 1,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N-1:0]      req_valid_i,
  output logic [N-1:0]      req_ready_o,
  input  logic [N*W-1:0]    req_x_i,
  input  logic [N*W-1:0]    req_y_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [ID_W-1:0]   rsp_id_o,
  output logic [W-1:0]      rsp_z_o,
  output logic              mul_start_o,
  output logic [W-1:0]      mul_x_o,
  output logic [W-1:0]      mul_y_o,
  input  logic [W-1:0]      mul_z_i,
  input  logic              mul_finish_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      mulX_q, mulX_d;
  logic [W-1:0]      mulY_q, mulY_d;
  logic [W-1:0]      rspZ_q, rspZ_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              grantValid;
  logic [ID_W-1:0]   grantIdx;
  logic [W-1:0]      selX;
  logic [W-1:0]      selY;

`ifndef FPHUB_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
  int                off;
  int                bestOff;
`endif

  // Grant selection. The requester to grant is chosen every cycle, and the
  // result is used only in IDLE. Its operands are selected in the same loop,
  // so no part-select is indexed by a variable.
`ifdef FPHUB_ARB_FIXED_PRIO_EN
  // The loop runs from the highest index down, so the lowest valid index is
  // the last one assigned and wins.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    selX       = '0;
    selY       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        grantValid = 1'b1;
        grantIdx   = ID_W'(i);
        selX       = req_x_i[i*W +: W];
        selY       = req_y_i[i*W +: W];
      end
    end
  end
`else
  // Each requester gets its distance from the round-robin pointer, wrapping
  // modulo N. The valid requester closest to the pointer wins.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    selX       = '0;
    selY       = '0;
    off        = 0;
    bestOff    = N;
    for (int i = 0; i < N; i++) begin
      off = (i >= int'(rrPtr_q)) ? (i - int'(rrPtr_q)) : (i - int'(rrPtr_q) + N);
      if (req_valid_i[i] && (off < bestOff)) begin
        bestOff    = off;
        grantValid = 1'b1;
        grantIdx   = ID_W'(i);
        selX       = req_x_i[i*W +: W];
        selY       = req_y_i[i*W +: W];
      end
    end
  end
`endif

  // Next-state and output logic. The operand registers load only on a grant.
  // This keeps mul_x_o/mul_y_o constant from the grant until the next one.
  // rsp_z_o loads only from a finish pulse seen in WAIT. A finish pulse in any
  // other state is ignored.
  always_comb begin
    state_d     = state_q;
    mulX_d      = mulX_q;
    mulY_d      = mulY_q;
    rspZ_d      = rspZ_q;
    id_d        = id_q;
`ifndef FPHUB_ARB_FIXED_PRIO_EN
    rrPtr_d     = rrPtr_q;
`endif
    req_ready_o = '0;
    mul_start_o = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grantValid) begin
          req_ready_o = N'(1) << grantIdx;
          mulX_d      = selX;
          mulY_d      = selY;
          id_d        = grantIdx;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mul_start_o = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (mul_finish_i) begin
          rspZ_d  = mul_z_i;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
`ifndef FPHUB_ARB_FIXED_PRIO_EN
          // The pointer moves to the requester after the one just served.
          // With N=1 it stays at 0.
          rrPtr_d = (id_q == ID_W'(N - 1)) ? '0 : id_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Synchronous reset returns the block to IDLE
  // and clears the held product and id, so rsp_valid_o drops right away.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mulX_q  <= '0;
      mulY_q  <= '0;
      rspZ_q  <= '0;
      id_q    <= '0;
`ifndef FPHUB_ARB_FIXED_PRIO_EN
      rrPtr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mulX_q  <= mulX_d;
      mulY_q  <= mulY_d;
      rspZ_q  <= rspZ_d;
      id_q    <= id_d;
`ifndef FPHUB_ARB_FIXED_PRIO_EN
      rrPtr_q <= rrPtr_d;
`endif
    end
  end

  assign mul_x_o  = mulX_q;
  assign mul_y_o  = mulY_q;
  assign rsp_z_o  = rspZ_q;
  assign rsp_id_o = id_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_fphub_mult_arbiter.sv
// tb_fphub_mult_arbiter
//   Testbench for fphub_mult_arbiter with N=4 and single-precision operands.
//   A stand-in FPHUB_mult model answers each start pulse two cycles later.
//   A timeline model of the arbiter (grant, +1 start, +4 response) predicts
//   every output.

module tb_fphub_mult_arbiter;

  localparam int N    = 4;
  localparam int W    = 32;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      reqValid;
  logic [N-1:0]      reqReady;
  logic [N*W-1:0]    reqX;
  logic [N*W-1:0]    reqY;
  logic              rspValid;
  logic              rspReady;
  logic [ID_W-1:0]   rspId;
  logic [W-1:0]      rspZ;
  logic              mulStart;
  logic [W-1:0]      mulX;
  logic [W-1:0]      mulY;
  logic [W-1:0]      mulZ;
  logic              mulFinish;
  logic              busy;

  int testsRun    = 0;
  int testsFailed = 0;

  // Free-running clock
  always #5 clk = ~clk;

  fphub_mult_arbiter #(.M(23), .E(8), .N(N)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_x_i      (reqX),
    .req_y_i      (reqY),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_id_o     (rspId),
    .rsp_z_o      (rspZ),
    .mul_start_o  (mulStart),
    .mul_x_o      (mulX),
    .mul_y_o      (mulY),
    .mul_z_i      (mulZ),
    .mul_finish_i (mulFinish),
    .busy_o       (busy)
  );

  // Behavioural stand-in for FPHUB_mult. HUB mantissas carry an implicit
  // leading one and an implicit trailing one. Zero and inf are special results.
  function automatic logic [31:0] hubMul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, ez;
    logic [49:0] p;
    logic [22:0] mz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 0 || eb == 0) return {s, 31'b0};
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'b0};
    p  = 50'({1'b1, a[22:0], 1'b1}) * 50'({1'b1, b[22:0], 1'b1});
    ez = ea + eb - 127;
    if (p[49]) begin
      ez = ez + 1;
      mz = p[48:26];
    end else begin
      mz = p[47:25];
    end
    if (ez <= 0) return {s, 31'b0};
    if (ez >= 255) return {s, 8'hFF, 23'b0};
    return {s, ez[7:0], mz};
  endfunction

  // Multiplier timing model. A start pulse seen at an edge raises finish two
  // cycles later. strayFinish injects finish pulses with junk data.
  logic [1:0]  finishPipe  = 2'b00;
  logic [31:0] prodHold    = '0;
  logic        strayFinish = 1'b0;
  logic [31:0] junkZ       = '0;

  always @(posedge clk) begin
    finishPipe <= {finishPipe[0], (mulStart === 1'b1)};
    if (mulStart === 1'b1) prodHold <= hubMul(mulX, mulY);
  end

  assign mulFinish = finishPipe[1] | strayFinish;
  assign mulZ      = finishPipe[1] ? prodHold : junkZ;

  // Advance to just after the next rising edge, where inputs are driven
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two-cycle reset with all inputs idle
  task automatic doReset;
    rst         = 1'b1;
    reqValid    = '0;
    rspReady    = 1'b0;
    strayFinish = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reset, then idle: every output must read zero
  task automatic test_reset;
    rst      = 1'b1;
    reqValid = '0;
    reqX     = '0;
    reqY     = '0;
    rspReady = 1'b0;
    tick();
    tick();
    @(negedge clk);
    testsRun++;
    if ({reqReady, rspValid, rspId, rspZ, mulStart, mulX, mulY, busy} !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b id=%0d z=%h st=%b x=%h y=%h busy=%b, expected all 0",
               reqReady, rspValid, rspId, rspZ, mulStart, mulX, mulY, busy);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk);
      testsRun++;
      if ({reqReady, rspValid, mulStart, busy} !== 4'b0 || rspZ !== '0) begin
        testsFailed++;
        $display("[TB] FAIL idle_outputs: got rdy=%b vld=%b st=%b busy=%b z=%h, expected all 0",
                 reqReady, rspValid, mulStart, busy, rspZ);
      end
    end
  endtask

  // One operation from requester 0, checked cycle by cycle
  task automatic test_single_op;
    logic [31:0] x, y;
    doReset();
    x = 32'h3F800000;
    y = 32'h40000000;
    reqX[0 +: W] = x;
    reqY[0 +: W] = y;
    reqValid = 4'b0001;
    rspReady = 1'b1;
    @(negedge clk);
    testsRun++;
    if (reqReady !== 4'b0001 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_grant: got rdy=%b busy=%b, expected rdy=0001 busy=0", reqReady, busy);
    end
    tick();
    reqValid = '0;
    @(negedge clk);
    testsRun++;
    if (mulStart !== 1'b1 || mulX !== x || mulY !== y || busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL single_issue: got st=%b x=%h y=%h busy=%b, expected st=1 x=%h y=%h busy=1",
               mulStart, mulX, mulY, busy, x, y);
    end
    for (int c = 2; c < 4; c++) begin
      tick();
      @(negedge clk);
      testsRun++;
      if (rspValid !== 1'b0 || mulStart !== 1'b0 || reqReady !== '0) begin
        testsFailed++;
        $display("[TB] FAIL single_wait%0d: got vld=%b st=%b rdy=%b, expected 0 0 0",
                 c, rspValid, mulStart, reqReady);
      end
    end
    tick();
    @(negedge clk);
    testsRun++;
    if (rspValid !== 1'b1 || rspId !== 2'd0 || rspZ !== hubMul(x, y)) begin
      testsFailed++;
      $display("[TB] FAIL single_resp: got vld=%b id=%0d z=%h, expected vld=1 id=0 z=%h",
               rspValid, rspId, rspZ, hubMul(x, y));
    end
    tick();
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0 || rspValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_done: got busy=%b vld=%b, expected 0 0", busy, rspValid);
    end
    rspReady = 1'b0;
  endtask

  // All requesters valid with no backpressure: check the grant order and
  // that grants are exactly 5 cycles apart
  task automatic test_round_robin;
    int grants, lastCycle, expId;
    logic [N-1:0] expReady;
    doReset();
    reqValid  = '1;
    rspReady  = 1'b1;
    grants    = 0;
    lastCycle = 0;
    for (int cyc = 0; cyc < 40 && grants < 5; cyc++) begin
      for (int i = 0; i < N; i++) begin
        reqX[i*W +: W] = $urandom;
        reqY[i*W +: W] = $urandom;
      end
      @(negedge clk);
      if (reqReady !== '0) begin
`ifdef FPHUB_ARB_FIXED_PRIO_EN
        expId = 0;
`else
        expId = grants % N;
`endif
        expReady = N'(1) << expId;
        testsRun++;
        if (reqReady !== expReady) begin
          testsFailed++;
          $display("[TB] FAIL rr_order%0d: got rdy=%b, expected %b", grants, reqReady, expReady);
        end
        if (grants > 0) begin
          testsRun++;
          if (cyc - lastCycle != 5) begin
            testsFailed++;
            $display("[TB] FAIL rr_spacing%0d: got %0d cycles, expected 5", grants, cyc - lastCycle);
          end
        end
        lastCycle = cyc;
        grants++;
      end
      tick();
    end
    testsRun++;
    if (grants != 5) begin
      testsFailed++;
      $display("[TB] FAIL rr_grant_count: got %0d grants, expected 5", grants);
    end
    reqValid = '0;
  endtask

  // Hold rsp_ready low for 10 cycles while the response is pending
  task automatic test_backpressure;
    logic [31:0] x, y, holdZ;
    logic found;
    doReset();
    x = $urandom;
    y = $urandom;
    reqX[1*W +: W] = x;
    reqY[1*W +: W] = y;
    reqValid = 4'b0010;
    rspReady = 1'b0;
    tick();
    reqValid = '1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (rspValid === 1'b1) found = 1'b1;
      else tick();
    end
    testsRun++;
    if (!found || rspId !== 2'd1 || rspZ !== hubMul(x, y)) begin
      testsFailed++;
      $display("[TB] FAIL bp_first_resp: got found=%b id=%0d z=%h, expected found=1 id=1 z=%h",
               found, rspId, rspZ, hubMul(x, y));
    end
    holdZ = hubMul(x, y);
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      testsRun++;
      if (rspValid !== 1'b1 || rspZ !== holdZ || rspId !== 2'd1 || reqReady !== '0 || mulStart !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL bp_hold%0d: got vld=%b z=%h id=%0d rdy=%b st=%b, expected 1 %h 1 0000 0",
                 c, rspValid, rspZ, rspId, reqReady, mulStart, holdZ);
      end
    end
    rspReady = 1'b1;
    tick();
    @(negedge clk);
    testsRun++;
`ifdef FPHUB_ARB_FIXED_PRIO_EN
    if (busy !== 1'b0 || rspValid !== 1'b0 || reqReady !== 4'b0001) begin
      testsFailed++;
      $display("[TB] FAIL bp_release: got busy=%b vld=%b rdy=%b, expected 0 0 0001", busy, rspValid, reqReady);
    end
`else
    if (busy !== 1'b0 || rspValid !== 1'b0 || reqReady !== 4'b0100) begin
      testsFailed++;
      $display("[TB] FAIL bp_release: got busy=%b vld=%b rdy=%b, expected 0 0 0100", busy, rspValid, reqReady);
    end
`endif
    reqValid = '0;
    rspReady = 1'b0;
  endtask

  // X is the special zero: the product is a signed zero and the latency is
  // still 4 cycles
  task automatic test_special_zero;
    logic [31:0] x, y;
    int lat;
    logic found;
    doReset();
    x = 32'h00000000;
    y = {$urandom_range(0, 1) == 1, 8'($urandom_range(1, 254)), 23'($urandom)};
    reqX[3*W +: W] = x;
    reqY[3*W +: W] = y;
    reqValid = 4'b1000;
    rspReady = 1'b1;
    @(negedge clk);
    testsRun++;
    if (reqReady !== 4'b1000) begin
      testsFailed++;
      $display("[TB] FAIL zero_grant: got rdy=%b, expected 1000", reqReady);
    end
    tick();
    reqValid = '0;
    lat   = 1;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      if (rspValid === 1'b1) found = 1'b1;
      else begin
        lat++;
        tick();
      end
    end
    testsRun++;
    if (!found || lat != 4) begin
      testsFailed++;
      $display("[TB] FAIL zero_latency: got found=%b lat=%0d, expected found=1 lat=4", found, lat);
    end
    testsRun++;
    if (rspZ !== {y[31], 31'b0} || rspId !== 2'd3) begin
      testsFailed++;
      $display("[TB] FAIL zero_result: got z=%h id=%0d, expected z=%h id=3", rspZ, rspId, {y[31], 31'b0});
    end
    tick();
    rspReady = 1'b0;
  endtask

  // Reset pulse in WAIT: the block returns to IDLE, and the late finish pulse
  // from the multiplier produces no response
  task automatic test_reset_in_wait;
    doReset();
    reqX[2*W +: W] = $urandom;
    reqY[2*W +: W] = $urandom;
    reqValid = 4'b0100;
    rspReady = 1'b1;
    tick();
    reqValid = '0;
    tick();
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b1 || mulStart !== 1'b0 || rspValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstwait_in_wait: got busy=%b st=%b vld=%b, expected 1 0 0", busy, mulStart, rspValid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0 || rspValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rstwait_idle: got busy=%b vld=%b, expected 0 0", busy, rspValid);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk);
      testsRun++;
      if (busy !== 1'b0 || rspValid !== 1'b0 || rspZ !== '0) begin
        testsFailed++;
        $display("[TB] FAIL rstwait_stray%0d: got busy=%b vld=%b z=%h, expected 0 0 0", c, busy, rspValid, rspZ);
      end
    end
    rspReady = 1'b0;
  endtask

  // Finish pulses in IDLE and in RESP must not change the state or rsp_z
  task automatic test_spurious_finish;
    logic [31:0] x, y, holdZ;
    logic found;
    doReset();
    junkZ       = $urandom | 32'h1;
    strayFinish = 1'b1;
    tick();
    strayFinish = 1'b0;
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0 || rspValid !== 1'b0 || rspZ !== '0) begin
      testsFailed++;
      $display("[TB] FAIL spur_idle: got busy=%b vld=%b z=%h, expected 0 0 0", busy, rspValid, rspZ);
    end
    x = $urandom;
    y = $urandom;
    reqX[0 +: W] = x;
    reqY[0 +: W] = y;
    reqValid = 4'b0001;
    rspReady = 1'b0;
    tick();
    reqValid = '0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (rspValid === 1'b1) found = 1'b1;
      else tick();
    end
    holdZ = hubMul(x, y);
    testsRun++;
    if (!found || rspZ !== holdZ) begin
      testsFailed++;
      $display("[TB] FAIL spur_resp: got found=%b z=%h, expected found=1 z=%h", found, rspZ, holdZ);
    end
    junkZ       = ~holdZ;
    strayFinish = 1'b1;
    tick();
    strayFinish = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      testsRun++;
      if (rspValid !== 1'b1 || busy !== 1'b1 || rspZ !== holdZ) begin
        testsFailed++;
        $display("[TB] FAIL spur_hold%0d: got vld=%b busy=%b z=%h, expected 1 1 %h", c, rspValid, busy, rspZ, holdZ);
      end
      tick();
    end
    rspReady = 1'b1;
    tick();
    @(negedge clk);
    testsRun++;
    if (busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL spur_release: got busy=%b, expected 0", busy);
    end
    rspReady = 1'b0;
  endtask

  // Random valids, operands and backpressure, checked against an operation
  // timeline: the grant cycle is age 0, start comes at age 1, and the
  // response is visible from age 4 until it is accepted
  task automatic test_random_traffic;
    logic         mBusy, found;
    int           mAge, mId, rrModel, g, cand;
    logic [31:0]  lastX, lastY, mZ;
    logic [N-1:0] expReady;
    logic         expStart, expValid;
    doReset();
    mBusy   = 1'b0;
    mAge    = 0;
    mId     = 0;
    rrModel = 0;
    lastX   = '0;
    lastY   = '0;
    mZ      = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reqValid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        reqX[i*W +: W] = $urandom;
        reqY[i*W +: W] = $urandom;
      end
      rspReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      found = 1'b0;
      g     = 0;
      if (!mBusy) begin
        for (int k = 0; k < N; k++) begin
`ifdef FPHUB_ARB_FIXED_PRIO_EN
          cand = k;
`else
          cand = (rrModel + k) % N;
`endif
          if (!found && reqValid[cand]) begin
            found = 1'b1;
            g     = cand;
          end
        end
      end
      expReady = found ? (N'(1) << g) : '0;
      expStart = mBusy && (mAge == 1);
      expValid = mBusy && (mAge >= 4);
      testsRun++;
      if (reqReady !== expReady || mulStart !== expStart || rspValid !== expValid || busy !== mBusy) begin
        testsFailed++;
        $display("[TB] FAIL rand_ctrl cyc%0d: got rdy=%b st=%b vld=%b busy=%b, expected %b %b %b %b",
                 cyc, reqReady, mulStart, rspValid, busy, expReady, expStart, expValid, mBusy);
      end
      testsRun++;
      if (mulX !== lastX || mulY !== lastY) begin
        testsFailed++;
        $display("[TB] FAIL rand_operands cyc%0d: got x=%h y=%h, expected x=%h y=%h", cyc, mulX, mulY, lastX, lastY);
      end
      if (expValid) begin
        testsRun++;
        if (rspId !== ID_W'(mId) || rspZ !== mZ) begin
          testsFailed++;
          $display("[TB] FAIL rand_resp cyc%0d: got id=%0d z=%h, expected id=%0d z=%h", cyc, rspId, rspZ, mId, mZ);
        end
      end
      if (found) begin
        mBusy = 1'b1;
        mAge  = 1;
        mId   = g;
        lastX = reqX[g*W +: W];
        lastY = reqY[g*W +: W];
        mZ    = hubMul(lastX, lastY);
      end else if (mBusy) begin
        if (expValid && rspReady) begin
          mBusy   = 1'b0;
          rrModel = (mId + 1) % N;
        end else begin
          mAge++;
        end
      end
      tick();
    end
    reqValid = '0;
    rspReady = 1'b0;
  endtask

  // Stops the run if the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    rst      = 1'b1;
    reqValid = '0;
    reqX     = '0;
    reqY     = '0;
    rspReady = 1'b0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_special_zero();
    test_reset_in_wait();
    test_spurious_finish();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
